// File: rtl/sine_dds_pwm.sv
// sine_dds_pwm: multi-channel sine PWM generator driven by a DDS phase
// accumulator. One shared quarter-wave ROM and one multiplier are walked
// across the channels by a small FSM once per PWM period; results land in
// shadow registers and are loaded into the active duty registers at the next
// period boundary, so duty never changes mid-period.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable            run/stop; low forces pwm_out to 0 and parks the counters
//   sync              phase restart request, applied at the next boundary
//   freq_word         phase increment added once per PWM period
//   amplitude         output scale, all ones is near full scale
//   phase_offset      per-channel offset, channel n at [n*PHASE_WIDTH +: PHASE_WIDTH]
//   pwm_out           one PWM output per channel
//   period_start      one-clk pulse on the first clk of each PWM period
//   wave_start        one-clk pulse when the accumulator wraps or is restarted
//
// Configuration macro: SINE_DDS_DITHER_EN adds a 16-bit LFSR whose LSB is
// added to each shadow value (saturating, amplitude 0 stays 0).

module sine_dds_pwm_lane #(
    parameter int RESOLUTION = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [RESOLUTION-1:0] shadow,
    input  logic [RESOLUTION-1:0] pwm_cnt,
    output logic                  pwm
);
    logic [RESOLUTION-1:0] duty_q;
    logic                  pwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            if (load) duty_q <= shadow;
            pwm_q <= enable && (pwm_cnt < duty_q);
        end
    end

    // Gate with enable so a stop takes effect without waiting for the flop.
    assign pwm = pwm_q & enable;
endmodule

module sine_dds_pwm #(
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24,
    parameter int RESOLUTION  = 8,
    parameter int LUT_BITS    = 8,
    parameter int PRESCALE    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            sync,
    input  logic [PHASE_WIDTH-1:0]          freq_word,
    input  logic [RESOLUTION-1:0]           amplitude,
    input  logic [CHANNELS*PHASE_WIDTH-1:0] phase_offset,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic                            period_start,
    output logic                            wave_start
);
    localparam int R     = RESOLUTION;
    localparam int PW    = PHASE_WIDTH;
    localparam int QW    = LUT_BITS - 2;
    localparam int QSIZE = 1 << QW;
    localparam int DIVW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [R-1:0] HALF = {1'b1, {(R-1){1'b0}}};

    // The calculation pass must fit inside one PWM period.
    if (PRESCALE < 1 || LUT_BITS < 3 || LUT_BITS > PHASE_WIDTH ||
        PRESCALE * (2 ** R) < 2 * CHANNELS + 2) begin : g_bad_cfg
        $error("sine_dds_pwm: need PRESCALE>=1, 3<=LUT_BITS<=PHASE_WIDTH, PRESCALE*2^RESOLUTION >= 2*CHANNELS+2");
    end

    // Quarter-wave ROM, sampled at bin centres so the mirrored half meets
    // the direct half without a duplicated endpoint.
    function automatic logic [R-1:0] q_entry(int k);
        real a;
        a = real'((1 << (R - 1)) - 1) *
            $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(QSIZE));
        return R'($rtoi(a + 0.5));
    endfunction

    logic [R-1:0] lut [QSIZE];
    for (genvar k = 0; k < QSIZE; k++) begin : g_lut
        localparam logic [R-1:0] QV = q_entry(k);
        assign lut[k] = QV;
    end

    // ---- tick divider, PWM counter, phase accumulator ----
    logic [DIVW-1:0] div_q;
    logic [R-1:0]    pwm_cnt;
    logic [PW-1:0]   phase_q;
    logic [PW:0]     phase_sum;
    logic            sync_pend, restart, tick, boundary;

    assign tick      = enable && (div_q == DIVW'(PRESCALE - 1));
    assign boundary  = tick && (&pwm_cnt);
    assign phase_sum = {1'b0, phase_q} + {1'b0, freq_word};
    assign restart   = sync_pend | sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            pwm_cnt      <= '0;
            phase_q      <= '0;
            sync_pend    <= 1'b0;
            period_start <= 1'b0;
            wave_start   <= 1'b0;
        end else begin
            period_start <= boundary;
            wave_start   <= boundary & (phase_sum[PW] | restart);
            if (!enable) begin
                div_q   <= '0;
                pwm_cnt <= '0;
            end else if (tick) begin
                div_q   <= '0;
                pwm_cnt <= pwm_cnt + R'(1);
            end else begin
                div_q   <= div_q + DIVW'(1);
            end
            if (boundary) begin
                phase_q   <= restart ? '0 : phase_sum[PW-1:0];
                sync_pend <= 1'b0;
            end else if (sync) begin
                sync_pend <= 1'b1;
            end
        end
    end

    // ---- calculation FSM: one ADDR + one MUL cycle per channel ----
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_MUL = 2'd2} state_t;
    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: if (boundary) begin
                state_d = S_ADDR;
                ch_d    = '0;
            end
            S_ADDR: state_d = S_MUL;
            S_MUL: begin
                if (ch_q == CHW'(CHANNELS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ADDR;
                    ch_d    = ch_q + CHW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [PW-1:0]       p_sum;
    logic [LUT_BITS-1:0] p_top;
    logic [1:0]          quad_q;
    logic [QW-1:0]       idx_q;
    logic [R-1:0]        s_val, scaled, shadow_val;
    logic [2*R-1:0]      prod;
    logic [CHANNELS-1:0][R-1:0] shadow_q;

    assign p_sum  = phase_q + phase_offset[ch_q*PW +: PW];
    assign p_top  = LUT_BITS'(p_sum >> (PW - LUT_BITS));
    // Upper half of the wave sits above mid-scale, lower half below it.
    assign s_val  = quad_q[1] ? HALF - lut[idx_q] : HALF + lut[idx_q];
    assign prod   = {{R{1'b0}}, s_val} * {{R{1'b0}}, amplitude};
    assign scaled = R'(prod >> R);

`ifdef SINE_DDS_DITHER_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         lfsr_q <= 16'h0001;
        else if (boundary) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign shadow_val = (amplitude == '0) ? '0 :
                        (&scaled)         ? scaled : scaled + R'(lfsr_q[0]);
`else
    assign shadow_val = scaled;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            quad_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (state_q == S_ADDR) begin
                quad_q <= p_top[LUT_BITS-1 -: 2];
                // Odd quadrants run the table backwards.
                idx_q  <= p_top[LUT_BITS-2] ? ~p_top[QW-1:0] : p_top[QW-1:0];
            end
            if (state_q == S_MUL) shadow_q[ch_q] <= shadow_val;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        sine_dds_pwm_lane #(.RESOLUTION(R)) u_lane (
            .clk     (clk),
            .rst     (reset),
            .enable  (enable),
            .load    (boundary),
            .shadow  (shadow_q[n]),
            .pwm_cnt (pwm_cnt),
            .pwm     (pwm_out[n])
        );
    end
endmodule

// File: tb/tb_sine_dds_pwm.sv
// Testbench for sine_dds_pwm (R=8, LUT_BITS=8, PW=24, PRESCALE=1, 2 channels).
// A period-level model tracks phase, shadow and duty per boundary; each
// period the bench counts high clks per channel and compares against the
// modelled duty, plus boundary spacing and wave_start.

module tb_sine_dds_pwm;
    localparam int CH = 2;
    localparam int PW = 24;
    localparam int R  = 8;
    localparam int LB = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1, enable = 1'b0, sync = 1'b0;
    logic [PW-1:0]   freq_word = '0;
    logic [R-1:0]    amplitude = '0;
    logic [CH*PW-1:0] phase_offset = '0;
    logic [CH-1:0]   pwm_out;
    logic            period_start, wave_start;

    int n_chk = 0, n_fail = 0;

    int unsigned m_phase;
    int          m_shadow [CH];
    int          m_duty   [CH];
    bit          m_pend, m_ws;

    sine_dds_pwm #(.CHANNELS(CH), .PHASE_WIDTH(PW), .RESOLUTION(R), .LUT_BITS(LB), .PRESCALE(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sync         (sync),
        .freq_word    (freq_word),
        .amplitude    (amplitude),
        .phase_offset (phase_offset),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .wave_start   (wave_start)
    );

    always #5 clk = ~clk;

    // Duty for a phase, straight from the sine formula.
    function automatic int sine_duty(int unsigned p, int amp);
        int  top, quad, idx, q;
        real ang;
        top  = int'((p >> (PW - LB)) % (1 << LB));
        quad = top / (1 << (LB - 2));
        idx  = top % (1 << (LB - 2));
        if (quad % 2 == 1) idx = (1 << (LB - 2)) - 1 - idx;
        ang  = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(1 << (LB - 2));
        q    = $rtoi(real'((1 << (R - 1)) - 1) * $sin(ang) + 0.5);
        return ((quad < 2) ? (1 << (R - 1)) + q : (1 << (R - 1)) - q) * amp / (1 << R);
    endfunction

    task automatic model_boundary();
        longint unsigned nxt;
        nxt  = longint'(m_phase) + longint'(freq_word);
        m_ws = (nxt >= 64'h100_0000) || m_pend;
        for (int c = 0; c < CH; c++) m_duty[c] = m_shadow[c];
        m_phase = m_pend ? 0 : int'(nxt % 64'h100_0000);
        m_pend  = 1'b0;
        for (int c = 0; c < CH; c++)
            m_shadow[c] = sine_duty((m_phase + phase_offset[c*PW +: PW]) % 32'h100_0000, int'(amplitude));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_phase = 0; m_pend = 1'b0; m_ws = 1'b0;
        for (int c = 0; c < CH; c++) begin m_shadow[c] = 0; m_duty[c] = 0; end
    endtask

    task automatic rand_inputs();
        freq_word = PW'($urandom);
        amplitude = R'($urandom);
        for (int c = 0; c < CH; c++) phase_offset[c*PW +: PW] = PW'($urandom);
    endtask

    // Waits (bounded) for period_start, steps the model, then watches the
    // 256 clks of that period. Inputs change / sync pulses mid-period.
    task automatic measure_period(input int limit, input bit do_rand, input bit do_sync,
                                  output int gap, output int hi0, output int hi1,
                                  output int extra, output bit ws, output bit to);
        gap = 0; hi0 = 0; hi1 = 0; extra = 0; ws = 1'b0; to = 1'b0;
        do begin @(negedge clk); gap++; end while (!period_start && gap < limit);
        if (!period_start) begin to = 1'b1; return; end
        ws = wave_start;
        model_boundary();
        for (int k = 0; k < 256; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (period_start || wave_start) extra++;
            end
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            if (k == 100 && do_rand) rand_inputs();
            if (k == 100 && do_sync) begin sync = 1'b1; m_pend = 1'b1; end
            if (k == 101) sync = 1'b0;
        end
    endtask

    task automatic test_reset();
        int gap, hi0, hi1, extra; bit ws, to;
        reset = 1'b1; enable = 1'b1; amplitude = 8'd255; freq_word = '0; phase_offset = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({pwm_out, period_start, wave_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0000", {pwm_out, period_start, wave_start});
        end
        do_reset();
        for (int p = 0; p < 3; p++) begin
            measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || gap !== ((p == 0) ? 256 : 1) || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL reset_period[%0d]: got gap=%0d hi=%0d/%0d ws=%0b extra=%0d to=%0b, want gap=%0d hi=%0d/%0d ws=%0b",
                         p, gap, hi0, hi1, ws, extra, to, (p == 0) ? 256 : 1, m_duty[0], m_duty[1], m_ws);
            end
        end
        n_chk++;
        if (hi0 !== 129) begin
            n_fail++;
            $display("FAIL fixed_phase_duty: got %0d high clks, want 129", hi0);
        end
    endtask

    task automatic test_amp_zero();
        int gap, hi0, hi1, extra; bit ws, to;
        amplitude = '0; freq_word = 24'h010000; phase_offset = '0;
        do_reset();
        for (int p = 0; p < 10; p++) begin
            measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || gap !== ((p == 0) ? 256 : 1) || hi0 !== 0 || hi1 !== 0 || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL amp_zero[%0d]: got gap=%0d hi=%0d/%0d ws=%0b extra=%0d to=%0b, want gap=%0d hi=0/0 ws=%0b",
                         p, gap, hi0, hi1, ws, extra, to, (p == 0) ? 256 : 1, m_ws);
            end
        end
    endtask

    task automatic test_quadrature();
        int gap, hi0, hi1, extra; bit ws, to;
        amplitude = 8'd255; freq_word = '0; phase_offset = '0; phase_offset[PW +: PW] = 24'h400000;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL quadrature[%0d]: got hi=%0d/%0d ws=%0b extra=%0d to=%0b, want hi=%0d/%0d ws=%0b",
                         p, hi0, hi1, ws, extra, to, m_duty[0], m_duty[1], m_ws);
            end
        end
        n_chk++;
        if (hi1 !== 254) begin
            n_fail++;
            $display("FAIL quadrature_peak: got ch1 high %0d clks, want 254", hi1);
        end
    endtask

    task automatic test_random();
        int gap, hi0, hi1, extra; bit ws, to;
        rand_inputs();
        do_reset();
        for (int p = 0; p < 12; p++) begin
            measure_period(300, 1'b1, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || gap !== ((p == 0) ? 256 : 1) || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL random[%0d]: got gap=%0d hi=%0d/%0d ws=%0b extra=%0d to=%0b, want gap=%0d hi=%0d/%0d ws=%0b",
                         p, gap, hi0, hi1, ws, extra, to, (p == 0) ? 256 : 1, m_duty[0], m_duty[1], m_ws);
            end
        end
    endtask

    task automatic test_sync();
        int gap, hi0, hi1, extra; bit ws, to;
        rand_inputs();
        freq_word = PW'($urandom_range(24'h0FFFFF, 24'h100000));
        amplitude = 8'd255;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            measure_period(300, 1'b0, p == 1, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL sync[%0d]: got hi=%0d/%0d ws=%0b extra=%0d to=%0b, want hi=%0d/%0d ws=%0b",
                         p, hi0, hi1, ws, extra, to, m_duty[0], m_duty[1], m_ws);
            end
            if (p == 2) begin
                n_chk++;
                if (ws !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sync_wave_start: got %0b, want 1", ws);
                end
            end
        end
    endtask

    task automatic test_wave();
        int gap, hi0, hi1, extra, n_ws, min0; bit ws, to;
        freq_word = 24'h010000; amplitude = 8'd255; phase_offset = '0;
        do_reset();
        n_ws = 0; min0 = 1000;
        for (int p = 0; p < 258; p++) begin
            measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_ws += int'(ws);
            if (p >= 2 && hi0 < min0) min0 = hi0;
            n_chk++;
            if (to !== 1'b0 || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL wave[%0d]: got hi=%0d/%0d ws=%0b extra=%0d to=%0b, want hi=%0d/%0d ws=%0b",
                         p, hi0, hi1, ws, extra, to, m_duty[0], m_duty[1], m_ws);
            end
        end
        n_chk++;
        if (n_ws !== 1) begin
            n_fail++;
            $display("FAIL wave_start_count: got %0d pulses in 258 periods, want 1", n_ws);
        end
        n_chk++;
        if (min0 > 1) begin
            n_fail++;
            $display("FAIL wave_min_duty: got %0d, want <= 1", min0);
        end
    endtask

    task automatic test_reset_mid();
        int gap, hi0, hi1, extra; bit ws, to;
        freq_word = '0; amplitude = 8'd255; phase_offset = '0;
        do_reset();
        for (int p = 0; p < 3; p++) measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!period_start && gap < 300);
        repeat (20) @(negedge clk);
        n_chk++;
        if (pwm_out !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got pwm_out=%b, want 11", pwm_out);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({pwm_out, period_start, wave_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b, want 0000", {pwm_out, period_start, wave_start});
        end
        do_reset();
        for (int p = 0; p < 3; p++) begin
            measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || gap !== ((p == 0) ? 256 : 1) || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL reset_mid_resume[%0d]: got gap=%0d hi=%0d/%0d ws=%0b to=%0b, want gap=%0d hi=%0d/%0d ws=%0b",
                         p, gap, hi0, hi1, ws, to, (p == 0) ? 256 : 1, m_duty[0], m_duty[1], m_ws);
            end
        end
    endtask

    task automatic test_enable();
        int gap, hi0, hi1, extra, ps_cnt; bit ws, to;
        freq_word = 24'h010000; amplitude = 8'd255; phase_offset = '0;
        phase_offset[PW +: PW] = PW'($urandom);
        do_reset();
        for (int p = 0; p < 4; p++) measure_period(300, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!period_start && gap < 300);
        n_chk++;
        if (period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_wait: got no period_start in %0d clks, want one", gap);
        end
        model_boundary();
        repeat (20) @(negedge clk);
        n_chk++;
        if (pwm_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_pre: got pwm_out[0]=%b, want 1", pwm_out[0]);
        end
        enable = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pwm_out !== 2'b00) begin
            n_fail++;
            $display("FAIL enable_off: got pwm_out=%b, want 00", pwm_out);
        end
        ps_cnt = 0;
        repeat (300) begin @(negedge clk); if (period_start) ps_cnt++; end
        n_chk++;
        if (ps_cnt !== 0) begin
            n_fail++;
            $display("FAIL enable_parked: got %0d period_start pulses while disabled, want 0", ps_cnt);
        end
        enable = 1'b1;
        for (int p = 0; p < 2; p++) begin
            measure_period(400, 1'b0, 1'b0, gap, hi0, hi1, extra, ws, to);
            n_chk++;
            if (to !== 1'b0 || gap !== ((p == 0) ? 256 : 1) || hi0 !== m_duty[0] || hi1 !== m_duty[1] || extra !== 0 || ws !== m_ws) begin
                n_fail++;
                $display("FAIL enable_resume[%0d]: got gap=%0d hi=%0d/%0d ws=%0b to=%0b, want gap=%0d hi=%0d/%0d ws=%0b",
                         p, gap, hi0, hi1, ws, to, (p == 0) ? 256 : 1, m_duty[0], m_duty[1], m_ws);
            end
        end
    endtask

    initial begin
        test_reset();
        test_amp_zero();
        test_quadrature();
        test_random();
        test_sync();
        test_wave();
        test_reset_mid();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
